// File: rtl/vga_timing_rx.sv
// vga_timing_rx: receive side of the VGA link. Registers the sync/pixel inputs,
// tracks line/frame position, validates geometry with a lock FSM and emits the
// active-pixel stream with coordinates two clocks after the input sample.
module vga_timing_rx #(
   parameter int unsigned H_SYNC  = 96,
   parameter int unsigned H_BACK  = 40,
   parameter int unsigned H_LEFT  = 8,
   parameter int unsigned H_VALID = 640,
   parameter int unsigned H_TOTAL = 800,
   parameter int unsigned V_SYNC  = 2,
   parameter int unsigned V_BACK  = 25,
   parameter int unsigned V_TOP   = 8,
   parameter int unsigned V_VALID = 480,
   parameter int unsigned V_TOTAL = 525
) (
   input  logic       vga_clk,
   input  logic       sys_rst,
   input  logic       hsync,
   input  logic       vsync,
   input  logic [7:0] vga_rgb,
   output logic       pix_valid,
   output logic [7:0] pix_data,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       line_start,
   output logic       frame_start,
   output logic       locked,
   output logic       timing_err
);

   localparam logic [9:0] CNT_MAX = 10'h3ff;
   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] HS_LAST = 10'(H_SYNC - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] X_START = 10'(H_SYNC + H_BACK + H_LEFT);
   localparam logic [9:0] X_END   = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID);
   localparam logic [9:0] Y_START = 10'(V_SYNC + V_BACK + V_TOP);
   localparam logic [9:0] Y_END   = 10'(V_SYNC + V_BACK + V_TOP + V_VALID);

   typedef enum logic [1:0] {SEEK, CHECK, LOCKED} state_t;

   state_t     state_reg, state_next;
   logic       hs_d, vs_d;
   logic [7:0] rgb_d;
   logic [9:0] cnt_h, cnt_v;
   logic       hs_rise, vs_rise, hs_fall;
   logic       violation;
   logic       in_window;
   logic       active;

   assign hs_rise = hsync & ~hs_d;
   assign vs_rise = vsync & ~vs_d;
   assign hs_fall = ~hsync & hs_d;

   // Stage 1: input registers plus line/frame position of the registered sample
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         hs_d  <= 1'b0;
         vs_d  <= 1'b0;
         rgb_d <= 8'h00;
         cnt_h <= 10'd0;
         cnt_v <= 10'd0;
      end else begin
         hs_d  <= hsync;
         vs_d  <= vsync;
         rgb_d <= vga_rgb;
         if (hs_rise)
            cnt_h <= 10'd0;
         else if (cnt_h != CNT_MAX)
            cnt_h <= cnt_h + 10'd1;
         // vs_rise takes priority so the normal coincident edge starts at line 0
         if (vs_rise)
            cnt_v <= 10'd0;
         else if (hs_rise && cnt_v != CNT_MAX)
            cnt_v <= cnt_v + 10'd1;
      end
   end

   // Geometry checks; only meaningful once a frame boundary has been seen
   always_comb begin
      violation = 1'b0;
      if (state_reg != SEEK) begin
         if (hs_rise && cnt_h != H_LAST)
            violation = 1'b1;
         if (hs_fall && cnt_h != HS_LAST)
            violation = 1'b1;
         if (cnt_h == CNT_MAX)
            violation = 1'b1;
         if (vs_rise && (cnt_v != V_LAST || !hs_rise))
            violation = 1'b1;
      end
   end

   // Lock FSM next state; a violation beats a simultaneous frame edge
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         SEEK:    if (vs_rise) state_next = CHECK;
         CHECK: begin
            if (violation)
               state_next = SEEK;
            else if (vs_rise)
               state_next = LOCKED;
         end
         LOCKED:  if (violation) state_next = SEEK;
         default: state_next = SEEK;
      endcase
   end

   // Lock FSM state register
   always_ff @(posedge vga_clk) begin
      if (sys_rst)
         state_reg <= SEEK;
      else
         state_reg <= state_next;
   end

   assign in_window = (cnt_h >= X_START) && (cnt_h < X_END) &&
                      (cnt_v >= Y_START) && (cnt_v < Y_END);
   assign active    = (state_reg == LOCKED) && in_window && !violation;

   // Stage 2: registered pixel stream, status and error pulse
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         pix_valid   <= 1'b0;
         pix_data    <= 8'h00;
         pix_x       <= CNT_MAX;
         pix_y       <= CNT_MAX;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         timing_err  <= 1'b0;
      end else begin
         pix_valid   <= active;
         pix_data    <= active ? rgb_d : 8'h00;
         pix_x       <= active ? (cnt_h - X_START) : CNT_MAX;
         pix_y       <= active ? (cnt_v - Y_START) : CNT_MAX;
         line_start  <= active && (cnt_h == X_START);
         frame_start <= active && (cnt_h == X_START) && (cnt_v == Y_START);
         locked      <= (state_next == LOCKED);
         timing_err  <= violation;
      end
   end

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: drives a reduced-geometry VGA source with random pixels and
// injected timing faults, and compares every output cycle with a frame-level model.
module tb_vga_timing_rx;

   localparam int HS  = 8;
   localparam int HB  = 4;
   localparam int HL  = 2;
   localparam int HV  = 16;
   localparam int HT  = 40;
   localparam int VS  = 2;
   localparam int VB  = 3;
   localparam int VT  = 1;
   localparam int VV  = 8;
   localparam int VTT = 20;
   localparam int X0  = HS + HB + HL;
   localparam int Y0  = VS + VB + VT;

   typedef struct packed {
      logic       v;
      logic [7:0] d;
      logic [9:0] x;
      logic [9:0] y;
      logic       ls;
      logic       fs;
   } pix_t;

   localparam pix_t RST_PIX = '{v: 1'b0, d: 8'h00, x: 10'h3ff, y: 10'h3ff, ls: 1'b0, fs: 1'b0};

   logic       vga_clk = 1'b0;
   logic       sys_rst;
   logic       hsync;
   logic       vsync;
   logic [7:0] vga_rgb;
   logic       pix_valid;
   logic [7:0] pix_data;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic       line_start;
   logic       frame_start;
   logic       locked;
   logic       timing_err;

   int   checks;
   int   errors;
   int   lock_cnt;      // clean frame edges seen since reset/fault, capped at 2
   bit   prev_vs;
   int   prev_hlen;
   pix_t exp_prev;
   int   dut_valid, dut_ls, dut_fs;

   vga_timing_rx #(
      .H_SYNC(HS), .H_BACK(HB), .H_LEFT(HL), .H_VALID(HV), .H_TOTAL(HT),
      .V_SYNC(VS), .V_BACK(VB), .V_TOP(VT), .V_VALID(VV), .V_TOTAL(VTT)
   ) dut (
      .vga_clk    (vga_clk),
      .sys_rst    (sys_rst),
      .hsync      (hsync),
      .vsync      (vsync),
      .vga_rgb    (vga_rgb),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .line_start (line_start),
      .frame_start(frame_start),
      .locked     (locked),
      .timing_err (timing_err)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic check_val(input string tag, input int obs, input int want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed %0d required %0d", tag, obs, want);
      end
   endtask

   // One input sample: update the model, clock it in, compare all outputs.
   task automatic step(input bit rst, input bit hs, input bit vs, input logic [7:0] rgb,
                       input bit bad, input int ax, input int ay);
      pix_t cur, want, obs;
      logic exp_err, exp_lock;
      sys_rst = rst;
      hsync   = hs;
      vsync   = vs;
      vga_rgb = rgb;
      exp_err = 1'b0;
      if (rst) begin
         lock_cnt = 0;
         prev_vs  = 1'b0;
      end else begin
         if (bad && lock_cnt > 0) begin
            exp_err  = 1'b1;
            lock_cnt = 0;
         end else if (vs && !prev_vs) begin
            lock_cnt = (lock_cnt == 0) ? 1 : 2;
         end
         prev_vs = vs;
      end
      exp_lock = (lock_cnt == 2);
      cur = RST_PIX;
      if (!rst && exp_lock && ax >= 0 && ay >= 0) begin
         cur.v  = 1'b1;
         cur.d  = rgb;
         cur.x  = 10'(ax);
         cur.y  = 10'(ay);
         cur.ls = (ax == 0);
         cur.fs = (ax == 0) && (ay == 0);
      end
      @(posedge vga_clk);
      #1;
      want = rst ? RST_PIX : exp_prev;
      obs  = {pix_valid, pix_data, pix_x, pix_y, line_start, frame_start};
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL pixel t=%0t observed v=%0b d=%h x=%0d y=%0d ls=%0b fs=%0b required v=%0b d=%h x=%0d y=%0d ls=%0b fs=%0b",
                $time, obs.v, obs.d, obs.x, obs.y, obs.ls, obs.fs,
                want.v, want.d, want.x, want.y, want.ls, want.fs);
      end
      checks++;
      assert ({locked, timing_err} === {exp_lock, exp_err}) else begin
         errors++;
         $error("FAIL status t=%0t observed locked=%0b err=%0b required locked=%0b err=%0b",
                $time, locked, timing_err, exp_lock, exp_err);
      end
      if (!rst) begin
         if (pix_valid)   dut_valid++;
         if (line_start)  dut_ls++;
         if (frame_start) dut_fs++;
      end
      exp_prev = cur;
   endtask

   // One frame of source timing with optional faults (-1 disables each).
   task automatic send_frame(input int short_line, input int short_hs_line, input int long_line,
                             input int rst_line, input int rst_pos, input bit pattern);
      for (int ln = 0; ln < VTT; ln++) begin
         int hlen, hsw;
         hlen = HT;
         if (ln == short_line) hlen = HT - 1;
         if (ln == long_line)  hlen = HT + 1100;
         hsw = (ln == short_hs_line) ? HS - 1 : HS;
         for (int p = 0; p < hlen; p++) begin
            int ax, ay;
            bit bad, rst;
            logic [7:0] rgb;
            ax  = (p >= X0 && p < X0 + HV) ? p - X0 : -1;
            ay  = (ln >= Y0 && ln < Y0 + VV) ? ln - Y0 : -1;
            rgb = (pattern && ax >= 0 && ay >= 0) ? 8'(ax ^ ay) : 8'($urandom);
            bad = (p == 0 && prev_hlen != HT) || (hsw != HS && p == hsw) || (p == 1024);
            rst = (ln == rst_line) && (p == rst_pos);
            step(rst, p < hsw, ln < VS, rgb, bad, ax, ay);
         end
         prev_hlen = hlen;
      end
   endtask

   task automatic clear_tally();
      dut_valid = 0;
      dut_ls    = 0;
      dut_fs    = 0;
   endtask

   task automatic check_frame(input string tag);
      check_val({tag, "_valid"}, dut_valid, HV * VV);
      check_val({tag, "_lines"}, dut_ls, VV);
      check_val({tag, "_frames"}, dut_fs, 1);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      lock_cnt  = 0;
      prev_vs   = 1'b0;
      prev_hlen = HT;
      exp_prev  = RST_PIX;
      clear_tally();
      sys_rst = 1'b1;
      hsync   = 1'b0;
      vsync   = 1'b0;
      vga_rgb = 8'h00;

      // reset state
      repeat (4) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, -1, -1);
      check_val("rst_pix_x", pix_x, 10'h3ff);
      check_val("rst_locked", locked, 0);

      // nominal source: lock after the second frame edge, then full frames
      send_frame(-1, -1, -1, -1, -1, 1'b0);
      check_val("t1_check_unlocked", locked, 0);
      send_frame(-1, -1, -1, -1, -1, 1'b0);
      clear_tally();
      send_frame(-1, -1, -1, -1, -1, 1'b1);
      check_frame("t2_pattern");
      clear_tally();
      send_frame(-1, -1, -1, -1, -1, 1'b0);
      check_frame("t1_random");

      // one short line while locked, then relock
      send_frame(int'($urandom_range(0, VTT - 2)), -1, -1, -1, -1, 1'b0);
      check_val("t3_lost", locked, 0);
      send_frame(-1, -1, -1, -1, -1, 1'b0);
      clear_tally();
      send_frame(-1, -1, -1, -1, -1, 1'b0);
      check_frame("t3_relock");
      check_val("t3_locked", locked, 1);

      // hsync stalled past counter saturation while locked
      send_frame(-1, -1, int'($urandom_range(0, VTT - 1)), -1, -1, 1'b0);
      check_val("t5_lost", locked, 0);

      // short hsync pulse while checking geometry
      send_frame(-1, int'($urandom_range(1, VTT - 1)), -1, -1, -1, 1'b0);
      check_val("t4_unlocked", locked, 0);
      send_frame(-1, -1, -1, -1, -1, 1'b0);
      send_frame(-1, -1, -1, -1, -1, 1'b1);
      check_val("t4_relocked", locked, 1);

      // reset in the middle of an active line
      send_frame(-1, -1, -1, Y0 + int'($urandom_range(0, VV - 1)),
                 X0 + int'($urandom_range(0, HV - 1)), 1'b0);
      check_val("t6_unlocked", locked, 0);
      send_frame(-1, -1, -1, -1, -1, 1'b0);
      clear_tally();
      send_frame(-1, -1, -1, -1, -1, 1'b1);
      check_frame("t6_relock");
      check_val("t6_locked", locked, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
